// File: rtl/parity_mem_pkg.sv
// Shared types, defaults and the parity helper for the parity-protected memory.
package parity_mem_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 256;
    localparam int ERR_CNT_W_DEF = 8;

    // Widest word the parity helper handles; callers zero-extend into it.
    localparam int PAR_MAX_W     = 64;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    // Even-parity bit of a zero-extended word: 1 when the word has an odd
    // number of ones. Zero padding does not change the result.
    function automatic logic calc_even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/parity_mem_array.sv
// Storage array: one synchronous write port and one registered read port.
module parity_mem_array #(
    parameter int WORD_W = 9,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage and read register; contents deliberately survive reset.
    // Callers only enable a port for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/parity_mem.sv
// Parity-protected single-port memory: init sweep FSM, parity generation,
// two-stage read with parity check, and error capture/counting.
module parity_mem
    import parity_mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 write,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 inj_err,
    input  logic                 clr_err,
    output logic                 ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    err_addr,
    output logic                 err_addr_vld
);

    localparam int                WORD_W    = DATA_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic                ready_q, ready_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_oor_q, rd_oor_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rd_valid_q, rd_valid_d;
    logic                parity_err_q, parity_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic                err_addr_vld_q, err_addr_vld_d;

    logic                we_s;
    logic [ADDR_W-1:0]   waddr_s;
    logic [WORD_W-1:0]   wdata_s;
    logic                re_s;
    logic [WORD_W-1:0]   rdata_s;
    logic                in_range_s;
    logic                wpar_s;
    logic                rd_err_s;

    assign in_range_s = ({1'b0, address} < DEPTH_EXT);
    // Inverting the generated bit is how a parity fault is planted.
    assign wpar_s     = calc_even_parity(PAR_MAX_W'(data_in)) ^ inj_err;

    parity_mem_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (pclk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .re    (re_s),
        .raddr (address),
        .rdata (rdata_s)
    );

    // Next state, sweep address, array port controls and first read stage.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        we_s      = 1'b0;
        waddr_s   = sweep_q;
        wdata_s   = {WORD_W{1'b0}};
        re_s      = 1'b0;
        rd_pend_d = 1'b0;
        rd_oor_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            INIT: begin
                // Clear one word per cycle; requests are ignored meanwhile.
                we_s    = 1'b1;
                waddr_s = sweep_q;
                if (sweep_q == LAST_ADDR) begin
                    state_d = IDLE;
                    sweep_d = {ADDR_W{1'b0}};
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (write) begin
                    // Write wins over a simultaneous read.
                    we_s    = in_range_s;
                    waddr_s = address;
                    wdata_s = {wpar_s, data_in};
                end else if (read) begin
                    re_s      = in_range_s;
                    rd_pend_d = 1'b1;
                    rd_oor_d  = ~in_range_s;
                    rd_addr_d = address;
                end else begin
                    rd_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = {ADDR_W{1'b0}};
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    assign rd_err_s = rd_pend_q & ~rd_oor_q & calc_even_parity(PAR_MAX_W'(rdata_s));

    // Second read stage: present data, check parity, update error tracking.
    always_comb begin
        data_out_d     = data_out_q;
        rd_valid_d     = rd_pend_q;
        parity_err_d   = rd_err_s;
        err_count_d    = err_count_q;
        err_addr_d     = err_addr_q;
        err_addr_vld_d = err_addr_vld_q;
        if (rd_pend_q) begin
            data_out_d = rd_oor_q ? {DATA_W{1'b0}} : rdata_s[DATA_W-1:0];
        end else begin
            data_out_d = data_out_q;
        end
        if (rd_err_s) begin
            // An error reported together with a clear restarts tracking on it.
            if (clr_err) begin
                err_count_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end else begin
                err_count_d = err_count_q;
            end
            if (clr_err || !err_addr_vld_q) begin
                err_addr_d     = rd_addr_q;
                err_addr_vld_d = 1'b1;
            end else begin
                err_addr_vld_d = err_addr_vld_q;
            end
        end else if (clr_err) begin
            err_count_d    = {ERR_CNT_W{1'b0}};
            err_addr_vld_d = 1'b0;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q        <= INIT;
            sweep_q        <= {ADDR_W{1'b0}};
            ready_q        <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_oor_q       <= 1'b0;
            rd_addr_q      <= {ADDR_W{1'b0}};
            data_out_q     <= {DATA_W{1'b0}};
            rd_valid_q     <= 1'b0;
            parity_err_q   <= 1'b0;
            err_count_q    <= {ERR_CNT_W{1'b0}};
            err_addr_q     <= {ADDR_W{1'b0}};
            err_addr_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            ready_q        <= ready_d;
            rd_pend_q      <= rd_pend_d;
            rd_oor_q       <= rd_oor_d;
            rd_addr_q      <= rd_addr_d;
            data_out_q     <= data_out_d;
            rd_valid_q     <= rd_valid_d;
            parity_err_q   <= parity_err_d;
            err_count_q    <= err_count_d;
            err_addr_q     <= err_addr_d;
            err_addr_vld_q <= err_addr_vld_d;
        end
    end

    assign ready        = ready_q;
    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign parity_err   = parity_err_q;
    assign err_count    = err_count_q;
    assign err_addr     = err_addr_q;
    assign err_addr_vld = err_addr_vld_q;

endmodule

// File: tb/tb_parity_mem.sv
// Randomised bench for parity_mem with a behavioural reference model.
module tb_parity_mem;

    localparam int DEPTH   = 256;
    localparam int CNT_MAX = 255;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       inj_err = 1'b0;
    logic       clr_err = 1'b0;
    logic       ready;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       parity_err;
    logic [7:0] err_count;
    logic [7:0] err_addr;
    logic       err_addr_vld;

    int n_pass  = 0;
    int n_total = 0;

    parity_mem dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .write        (write),
        .read         (read),
        .address      (address),
        .data_in      (data_in),
        .inj_err      (inj_err),
        .clr_err      (clr_err),
        .ready        (ready),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .parity_err   (parity_err),
        .err_count    (err_count),
        .err_addr     (err_addr),
        .err_addr_vld (err_addr_vld)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] mem_m [DEPTH];
    int         init_left = DEPTH;
    bit         chk_en = 1'b0;
    bit         pend_v = 1'b0;
    int         pend_data, pend_addr;
    bit         pend_err;
    int         exp_data = 0, exp_cnt = 0, exp_eaddr = 0;
    bit         exp_ready = 1'b0, exp_valid = 1'b0, exp_perr = 1'b0, exp_evld = 1'b0;

    // Model advances on each edge from the inputs the DUT samples.
    always @(posedge pclk) begin
        if (!rst_n) begin
            chk_en    = 1'b1;
            init_left = DEPTH;
            pend_v    = 1'b0;
            exp_ready = 1'b0;
            exp_valid = 1'b0;
            exp_perr  = 1'b0;
            exp_data  = 0;
            exp_cnt   = 0;
            exp_eaddr = 0;
            exp_evld  = 1'b0;
        end else begin
            exp_valid = pend_v;
            exp_perr  = pend_v && pend_err;
            if (pend_v) exp_data = pend_data;
            if (exp_perr) begin
                exp_cnt = clr_err ? 1 : ((exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX);
                if (clr_err || !exp_evld) begin
                    exp_eaddr = pend_addr;
                    exp_evld  = 1'b1;
                end
            end else if (clr_err) begin
                exp_cnt  = 0;
                exp_evld = 1'b0;
            end
            pend_v = 1'b0;
            if (init_left > 0) begin
                mem_m[DEPTH - init_left] = 9'h000;
                init_left--;
            end else if (write) begin
                mem_m[address] = {inj_err ? ~^data_in : ^data_in, data_in};
            end else if (read) begin
                pend_v    = 1'b1;
                pend_addr = address;
                pend_data = mem_m[address][7:0];
                pend_err  = ($countones(mem_m[address]) % 2) == 1;
            end
            exp_ready = (init_left == 0);
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge pclk) begin
        if (chk_en) begin
            check("ready", ready, exp_ready);
            check("rd_valid", rd_valid, exp_valid);
            check("parity_err", parity_err, exp_perr);
            check("data_out", data_out, exp_data);
            check("err_count", err_count, exp_cnt);
            check("err_addr_vld", err_addr_vld, exp_evld);
            check("err_addr", err_addr, exp_eaddr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic r, input logic [7:0] a,
                        input logic [7:0] d, input logic inj, input logic clr);
        write   = w;
        read    = r;
        address = a;
        data_in = d;
        inj_err = inj;
        clr_err = clr;
        @(negedge pclk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b1, a, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic inj);
        step(1'b1, 1'b0, a, d, inj, 1'b0);
    endtask

    // Counts cycles until ready rises, optionally firing random requests.
    task automatic wait_ready(input bit noisy, output int n);
        n = 0;
        do begin
            if (noisy)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'b0);
            else
                idle();
            n++;
        end while (!ready && n < 1000);
    endtask

    initial begin
        int n;
        @(negedge pclk);
        rst_n = 1'b0;
        repeat (3) idle();
        check("rst_ready", ready, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_err_count", err_count, 32'd0);
        rst_n = 1'b1;
        wait_ready(1'b0, n);
        check("init_cycles", n, 32'd256);

        // Post-init reads of swept words.
        rd(8'h00);
        rd(8'h7F);
        rd(8'hFF);
        idle();
        check("init_rd_ff_data", data_out, 32'h00);
        check("init_rd_ff_valid", rd_valid, 32'd1);
        check("init_rd_ff_perr", parity_err, 32'd0);

        // Write then read back-to-back.
        wr(8'h10, 8'hA5, 1'b0);
        rd(8'h10);
        idle();
        check("wr_rd_valid", rd_valid, 32'd1);
        check("wr_rd_data", data_out, 32'hA5);
        check("wr_rd_perr", parity_err, 32'd0);

        // Injected parity errors.
        wr(8'h20, 8'h3C, 1'b1);
        wr(8'h30, 8'h11, 1'b1);
        rd(8'h20);
        idle();
        check("inj_perr", parity_err, 32'd1);
        check("inj_cnt1", err_count, 32'd1);
        check("inj_addr", err_addr, 32'h20);
        check("inj_vld", err_addr_vld, 32'd1);
        rd(8'h30);
        idle();
        check("inj2_cnt", err_count, 32'd2);
        check("inj2_addr", err_addr, 32'h20);

        // Collision: write wins, no read.
        step(1'b1, 1'b1, 8'h05, 8'h55, 1'b0, 1'b0);
        idle();
        check("coll_no_valid", rd_valid, 32'd0);
        rd(8'h05);
        idle();
        check("coll_data", data_out, 32'h55);

        // Saturation, clear, and clear colliding with an error.
        repeat (260) rd(8'h20);
        idle();
        check("sat_cnt", err_count, 32'd255);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("clr_cnt", err_count, 32'd0);
        check("clr_vld", err_addr_vld, 32'd0);
        rd(8'h30);
        rd(8'h30);
        rd(8'h20);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("clr_err_cnt", err_count, 32'd1);
        check("clr_err_addr", err_addr, 32'h20);
        check("clr_err_vld", err_addr_vld, 32'd1);

        // Randomised traffic, biased towards a few hot addresses.
        for (int i = 0; i < 3000; i++) begin
            int op;
            logic [7:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            step(op <= 3 || op == 8, (op >= 4 && op <= 8), a, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end
        idle();

        // Reset in the middle of the sweep, with requests during INIT.
        rst_n = 1'b0;
        repeat (2) idle();
        rst_n = 1'b1;
        repeat (100) idle();
        rst_n = 1'b0;
        repeat (2) idle();
        rst_n = 1'b1;
        wait_ready(1'b1, n);
        check("resweep_cycles", n, 32'd256);
        idle();
        for (int a = 0; a < DEPTH; a++) rd(8'(a));
        rd(8'h10);
        idle();
        check("resweep_rd_data", data_out, 32'h00);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/parity_mem.md
# parity_mem

Parametrised, parity-protected single-port memory for the `pclk` domain. It is the next generation of the team's 8-bit even-parity memory model and adds the following:
- configurable data width and depth;
- a registered read with a valid strobe;
- parity checking on read, with error reporting and a saturating error counter;
- a post-reset initialisation sweep;
- a parity-error injection hook for verification.

It sits behind the memory interface as the synthesizable storage for bus-side reads and writes.

## Interface
Parameters:
- `DATA_W`, 8: data bits per word. The stored word is `DATA_W+1` bits (parity in the MSB).
- `DEPTH`, 256: number of words. `DEPTH` ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `ERR_CNT_W`, 8: width of the error counter.

Ports:
- `pclk`  in  1  clock. The only clock.
- `rst_n`  in  1  reset. Synchronous, active-low, sampled on the rising edge of `pclk`.
- `write`  in  1  write request.
- `read`  in  1  read request.
- `address`  in  `ADDR_W`  word address.
- `data_in`  in  `DATA_W`  write data.
- `inj_err`  in  1  when set with `write`, the parity bit is stored inverted.
- `clr_err`  in  1  clears `err_count` and `err_addr_vld`.
- `ready`  out  1  block accepts requests.
- `data_out`  out  `DATA_W`  read data.
- `rd_valid`  out  1  `data_out` and `parity_err` are valid this cycle.
- `parity_err`  out  1  the read word failed the even-parity check.
- `err_count`  out  `ERR_CNT_W`  parity errors seen since reset or the last clear. Saturating.
- `err_addr`  out  `ADDR_W`  address of the first error since the last clear.
- `err_addr_vld`  out  1  `err_addr` holds a captured address.

## Operation
- **Parity rule.** The stored parity bit is the XOR of the data bits, so the stored word always carries an even number of ones. With `inj_err` set, the stored parity bit is `~^data_in` instead.
- **FSM states:** `INIT` and `IDLE`.
  - Reset forces `INIT` with the sweep address at 0.
  - In `INIT`, one word per cycle is written with data 0 and parity 0, addresses 0 to `DEPTH-1`. After the write to address `DEPTH-1`, the FSM moves to `IDLE`.
  - `ready` is 1 only in `IDLE`.
- **Request gating.** Requests are accepted only when `ready` is 1. Requests while `ready` is 0 are dropped, with no side effects.
- **Write.** With `write` high, the word at `address` is updated at the clock edge.
- **Read.** With `read` high and `write` low, the word at `address` is read and checked.
- **Simultaneous write and read:** the write wins. No read takes place and `rd_valid` stays 0.
- **Out-of-range address** (`address` ≥ `DEPTH`, possible only when `DEPTH` is not a power of 2):
  - a write is dropped;
  - a read returns `data_out` = 0 with `rd_valid` = 1 and `parity_err` = 0.
- **Parity error on read:**
  - `parity_err` = 1, in the same cycle as `rd_valid`;
  - `err_count` increments, saturating at all-ones;
  - if `err_addr_vld` is 0, `err_addr` captures the address and `err_addr_vld` is set to 1.
- **`clr_err`.** Sets `err_count` to 0 and `err_addr_vld` to 0. If an error is reported in the same cycle, the error wins over the clear: `err_count` = 1, and `err_addr` captures that address with `err_addr_vld` = 1.

## Timing
- **Reset values:** `ready` 0, `data_out` 0, `rd_valid` 0, `parity_err` 0, `err_count` 0, `err_addr` 0, `err_addr_vld` 0.
- **Initialisation latency.** Reset is released at edge R. `ready` rises after edge R+`DEPTH`, giving exactly `DEPTH` cycles of `INIT`.
- **Reset during `INIT`** restarts the sweep from address 0. Memory contents are otherwise not cleared by reset.
- **Read latency** is 1 cycle. For a read accepted at edge N, `data_out`, `rd_valid` and `parity_err` are valid after edge N+1.
  - `rd_valid` and `parity_err` are single-cycle pulses.
  - `data_out` holds its value until the next read.
- **Error counters** update at the same edge that asserts `parity_err`.
- **Write to read.** A write at edge N is visible to a read accepted at edge N+1 (back-to-back read-after-write returns the new data).
- **Throughput:** one request per cycle, with no stalls in `IDLE`.

## Structure
- **Package `parity_mem_pkg`:**
  - the state enum `{INIT, IDLE}`;
  - the function `calc_even_parity`, parametrised through a width argument or a fixed maximum width;
  - the default parameter constants.
- **Sub-module `parity_mem_array`:** the storage array with one synchronous write port and one synchronous read port, `DATA_W+1` wide.
- **Top level:** the FSM, parity generation and checking, and the error logic.

## Test plan
- **Initialisation.** Release reset with `DEPTH` = 256. Expect `ready` to be 0 for 256 cycles and then 1. Reads of addresses 0x00, 0x7F and 0xFF each return 0 with `parity_err` = 0.
- **Write/read.** Write 0xA5 to address 0x10, then read it the next cycle. One cycle later expect `rd_valid` = 1, `data_out` = 0xA5 and `parity_err` = 0.
- **Error injection.** Write 0x3C to address 0x20 with `inj_err` = 1, then read address 0x20. Expect `parity_err` = 1, `err_count` = 1, `err_addr` = 0x20 and `err_addr_vld` = 1. A second bad read of address 0x30 leaves `err_addr` at 0x20 and sets `err_count` = 2.
- **Collision.** Assert `write` (0x55 to address 0x05) and `read` in the same cycle. Expect `rd_valid` to stay 0. A subsequent read of address 0x05 returns 0x55.
- **Saturation and clear.**
  - 260 bad reads with `ERR_CNT_W` = 8 leave `err_count` at 255.
  - `clr_err` alone sets it to 0.
  - `clr_err` in the same cycle as a bad read gives `err_count` = 1.
- **Reset mid-sweep.** Assert `rst_n` = 0 at cycle 100 of `INIT`. Expect `ready` to stay low for a full 256 cycles after release, and requests issued during that time to have no effect.
